// File: rtl/mult_pkg.sv
// Shared types and helpers for the shift-and-add multiplier.
// The state encoding and the iteration-counter width both live here.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // ceil(log2(size)), at least 1 bit; sized for operand widths up to 2^16.
  function automatic int unsigned count_width(input int unsigned size);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 16; i++) begin
      if ((32'd1 << i) < size) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/multiplication.sv
// Sequential shift-and-add unsigned multiplier, one multiplier bit per cycle.
// Optional macro MULT_EARLY_EXIT_EN: stop iterating once the remaining multiplier bits are zero.
module multiplication
  import mult_pkg::*;
#(
  parameter int unsigned SIZE = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SIZE-1:0]   input_multiplicand_tdata,
  input  logic              input_multiplicand_tvalid,
  output logic              input_multiplicand_tready,
  input  logic [SIZE-1:0]   input_multiplier_tdata,
  input  logic              input_multiplier_tvalid,
  output logic              input_multiplier_tready,
  output logic [2*SIZE-1:0] output_tdata,
  output logic              output_tvalid,
  input  logic              output_tready
);

  localparam int unsigned           CW   = count_width(SIZE);
  localparam int unsigned           PW   = 2 * SIZE;
  localparam logic [CW-1:0]         LAST = CW'(SIZE - 1);

  state_e          state_q;
  logic            ready_q;
  logic [PW-1:0]   acc_q;
  logic [PW-1:0]   mcand_q;
  logic [SIZE-1:0] mplier_q;
  logic [CW-1:0]   count_q;
  logic [PW-1:0]   out_data_q;
  logic            out_valid_q;

  logic            accept;
  logic            early_exit;
  logic [PW-1:0]   acc_d;

  // ready_q mirrors "in IDLE" but stays low while reset is applied and for
  // the first cycle after it, so no operand is taken during reset.
  assign accept                    = ready_q & input_multiplicand_tvalid & input_multiplier_tvalid;
  assign input_multiplicand_tready = accept;
  assign input_multiplier_tready   = accept;
  assign output_tdata              = out_data_q;
  assign output_tvalid             = out_valid_q;

  // NOTE: every signal driven from always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    acc_d      = acc_q;
    early_exit = 1'b0;
    if (mplier_q[0]) acc_d = acc_q + mcand_q;
`ifdef MULT_EARLY_EXIT_EN
    early_exit = (mplier_q == '0);
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the datapath registers are reset too, so a reset mid-RUN or in
    // DONE can never leak a partial product into the next result.
    if (!rst_n) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      count_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            acc_q    <= '0;
            mcand_q  <= {{SIZE{1'b0}}, input_multiplicand_tdata};
            mplier_q <= input_multiplier_tdata;
            count_q  <= '0;
            ready_q  <= 1'b0;
            state_q  <= RUN;
          end
        end

        RUN: begin
          if (early_exit) begin
            state_q <= DONE;
          end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            count_q  <= count_q + 1'b1;
            if (count_q == LAST) state_q <= DONE;
          end
        end

        DONE: begin
          // First DONE cycle registers the product; it is then held until taken.
          if (!out_valid_q) begin
            out_data_q  <= acc_q;
            out_valid_q <= 1'b1;
          end else if (output_tready) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            ready_q     <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          ready_q     <= 1'b0;
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiplication.sv
// Self-checking bench for multiplication: directed cases plus random operands
// compared against a plain-arithmetic product and latency model.
module tb_multiplication;

  localparam int unsigned SIZE = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [SIZE-1:0]   mcand_data;
  logic              mcand_valid;
  logic              mcand_ready;
  logic [SIZE-1:0]   mplier_data;
  logic              mplier_valid;
  logic              mplier_ready;
  logic [2*SIZE-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  int checks = 0;
  int errors = 0;

  multiplication #(.SIZE(SIZE)) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .input_multiplicand_tdata  (mcand_data),
    .input_multiplicand_tvalid (mcand_valid),
    .input_multiplicand_tready (mcand_ready),
    .input_multiplier_tdata    (mplier_data),
    .input_multiplier_tvalid   (mplier_valid),
    .input_multiplier_tready   (mplier_ready),
    .output_tdata              (out_data),
    .output_tvalid             (out_valid),
    .output_tready             (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Edges from accept to output_tvalid visible: RUN cycles plus one.
  function automatic int ref_latency(input logic [SIZE-1:0] b);
    int runs;
`ifdef MULT_EARLY_EXIT_EN
    int p;
    p = -1;
    for (int i = 0; i < int'(SIZE); i++) if (b[i]) p = i;
    runs = (p + 2 < int'(SIZE)) ? p + 2 : int'(SIZE);
`else
    runs = (b === 'x) ? 0 : int'(SIZE);
`endif
    return runs + 1;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic accept_op(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b, input string tag);
    bit got;
    got          = 1'b0;
    mcand_data   = a;
    mplier_data  = b;
    mcand_valid  = 1'b1;
    mplier_valid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      #1;
      got = mcand_ready && mplier_ready;
      if (got) check({tag, "_tready_pair"}, 128'(mplier_ready), 128'(mcand_ready));
      @(negedge clk);
    end
    check({tag, "_accepted"}, 128'(got), 128'd1);
    check({tag, "_tready_low_in_run"}, 128'({mcand_ready, mplier_ready}), 128'd0);
    mcand_valid  = 1'b0;
    mplier_valid = 1'b0;
    mcand_data   = '1;
    mplier_data  = '1;
  endtask

  // Waits for the product, holds it under backpressure, then takes it.
  task automatic finish_op(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                           input int hold, input string tag);
    int            n;
    logic [127:0]  expected;
    logic [127:0]  held;
    bit            stable;
    expected = 128'(a) * 128'(b);
    n = 0;
    while (!out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 128'(n), 128'(ref_latency(b)));
    check({tag, "_product"}, out_data, expected);
    held   = out_data;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!out_valid || out_data !== held) stable = 1'b0;
    end
    if (hold > 0) check({tag, "_held_stable"}, 128'(stable), 128'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 128'(out_valid), 128'd0);
  endtask

  task automatic run_op(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                        input int hold, input string tag);
    accept_op(a, b, tag);
    finish_op(a, b, hold, tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [SIZE-1:0] ra;
    logic [SIZE-1:0] rb;
    bit              quiet;

    rst_n        = 1'b0;
    mcand_data   = '0;
    mplier_data  = '0;
    mcand_valid  = 1'b1;
    mplier_valid = 1'b1;
    out_ready    = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_tdata", out_data, 128'd0);
    check("reset_tvalid", 128'(out_valid), 128'd0);
    check("reset_treadys", 128'({mcand_ready, mplier_ready}), 128'd0);
    mcand_valid  = 1'b0;
    mplier_valid = 1'b0;
    out_ready    = 1'b0;
    rst_n        = 1'b1;
    @(negedge clk);

    run_op(64'd3, 64'd5, 0, "a3_b5");
    run_op('1, '1, 2, "all_ones");
    check("all_ones_const", 128'hFFFFFFFFFFFFFFFE_0000000000000001, 128'(64'hFFFF_FFFF_FFFF_FFFF) * 128'(64'hFFFF_FFFF_FFFF_FFFF));
    run_op(64'h1234, 64'd0, 0, "b_zero");
    run_op(64'hDEAD, 64'd1, 0, "b_one");

    // A lone multiplicand must never be accepted.
    mcand_data  = 64'd7;
    mcand_valid = 1'b1;
    quiet       = 1'b1;
    repeat (10) begin
      #1;
      if (mcand_ready || mplier_ready) quiet = 1'b0;
      @(negedge clk);
    end
    check("lone_operand_no_tready", 128'(quiet), 128'd1);
    run_op(64'd7, 64'd9, 0, "a7_b9");

    run_op(64'd2, 64'd3, 20, "bp_first");
    run_op(64'd4, 64'd5, 0, "bp_second");

    // Reset in the middle of RUN, with operands offered throughout.
    accept_op(64'hFFFF_0000_1234_5678, 64'hFFFF_FFFF_FFFF_FFFF, "pre_reset");
    repeat (29) @(negedge clk);
    mcand_valid  = 1'b1;
    mplier_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("midrun_reset_tvalid", 128'(out_valid), 128'd0);
    check("midrun_reset_treadys", 128'({mcand_ready, mplier_ready}), 128'd0);
    check("midrun_reset_tdata", out_data, 128'd0);
    @(negedge clk);
    @(negedge clk);
    check("midrun_reset_treadys_held", 128'({mcand_ready, mplier_ready}), 128'd0);
    mcand_valid  = 1'b0;
    mplier_valid = 1'b0;
    rst_n        = 1'b1;
    @(negedge clk);
    run_op(64'd6, 64'd7, 0, "after_reset");

    for (int i = 0; i < 16; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rb = rb >> $urandom_range(0, 64);
      run_op(ra, rb, int'($urandom_range(0, 3)), $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
